// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter sharing one slave between fetch (m0) and mem (m1).
// Grant is registered and held for the whole cycle; a stalled strobe times out to err.
module wb_arbiter2 #(
  parameter int RR_MODE        = 0,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           nxt;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant_q;
  logic             g0;
  logic             g1;
  logic             pick1;
  logic             tmo;
  logic             bus_err;

  assign g0 = (state == GNT0);
  assign g1 = (state == GNT1);

  // Contention goes to m1, or to whoever did not own the bus last.
  assign pick1 = (RR_MODE != 0) ? ~last : 1'b1;

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_addr_o = '0;
    s_dat_o  = '0;
    unique case (1'b1)
      g0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_addr_o = m0_addr_i;
        s_dat_o  = m0_dat_i;
      end
      g1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_addr_o = m1_addr_i;
        s_dat_o  = m1_dat_i;
      end
      default: ;
    endcase
  end

  // cnt holds completed stall cycles, so this fires on the Nth one.
  assign tmo = TMO_EN && s_stb_o && !s_ack_i
            && !s_err_i && (cnt == TMO_LAST);
  assign bus_err = s_err_i | tmo;

  assign m0_ack_o = g0 & s_ack_i;
  assign m0_err_o = g0 & bus_err;
  assign m1_ack_o = g1 & s_ack_i;
  assign m1_err_o = g1 & bus_err;
  assign m_dat_o  = s_dat_i;
  assign grant_o  = grant_q;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (m1_cyc_i && (!m0_cyc_i || pick1))
          nxt = GNT1;
        else if (m0_cyc_i)
          nxt = GNT0;
      end
      GNT0: if (!m0_cyc_i) nxt = IDLE;
      GNT1: if (!m1_cyc_i) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      grant_q <= 2'b00;
      last    <= 1'b1;
      cnt     <= '0;
    end else begin
      state   <= nxt;
      grant_q <= {nxt == GNT1, nxt == GNT0};
      if (g0 && !m0_cyc_i) last <= 1'b0;
      if (g1 && !m1_cyc_i) last <= 1'b1;
      if (state == IDLE || !s_stb_o || s_ack_i
          || s_err_i || tmo)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Scoreboard bench for wb_arbiter2: fixed-priority and round-robin
// instances share stimulus; a negedge monitor checks the selected one.
module tb_wb_arbiter2;

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_1004;
  localparam logic [31:0] DR = 32'hCAFE_0001;

  logic clk = 1'b0;
  logic rst_i;
  logic m0_cyc, m0_stb, m0_we;
  logic m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_addr, m1_addr, m0_dat, m1_dat;
  logic [31:0] s_dat_i;
  logic s_ack, s_err;

  logic f_m0_ack, f_m0_err, f_m1_ack, f_m1_err;
  logic f_s_cyc, f_s_stb, f_s_we;
  logic [3:0]  f_s_sel;
  logic [31:0] f_s_addr, f_s_dat, f_m_dat;
  logic [1:0]  f_grant;

  logic r_m0_ack, r_m0_err, r_m1_ack, r_m1_err;
  logic r_s_cyc, r_s_stb, r_s_we;
  logic [3:0]  r_s_sel;
  logic [31:0] r_s_addr, r_s_dat, r_m_dat;
  logic [1:0]  r_grant;

  always #5 clk = ~clk;

  wb_arbiter2 #(.RR_MODE(0), .TIMEOUT_CYCLES(4), .CNT_W(8)) u_fp (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_addr_i(m0_addr), .m0_dat_i(m0_dat),
    .m0_ack_o(f_m0_ack), .m0_err_o(f_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_addr_i(m1_addr), .m1_dat_i(m1_dat),
    .m1_ack_o(f_m1_ack), .m1_err_o(f_m1_err),
    .m_dat_o(f_m_dat),
    .s_cyc_o(f_s_cyc), .s_stb_o(f_s_stb), .s_we_o(f_s_we),
    .s_sel_o(f_s_sel), .s_addr_o(f_s_addr), .s_dat_o(f_s_dat),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(f_grant)
  );

  wb_arbiter2 #(.RR_MODE(1), .TIMEOUT_CYCLES(4), .CNT_W(8)) u_rr (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_addr_i(m0_addr), .m0_dat_i(m0_dat),
    .m0_ack_o(r_m0_ack), .m0_err_o(r_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_addr_i(m1_addr), .m1_dat_i(m1_dat),
    .m1_ack_o(r_m1_ack), .m1_err_o(r_m1_err),
    .m_dat_o(r_m_dat),
    .s_cyc_o(r_s_cyc), .s_stb_o(r_s_stb), .s_we_o(r_s_we),
    .s_sel_o(r_s_sel), .s_addr_o(r_s_addr), .s_dat_o(r_s_dat),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(r_grant)
  );

  typedef struct {
    string       tag;
    logic [1:0]  grant;
    logic        cyc;
    logic [3:0]  resp;
    logic        chk;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic sel = 1'b0;

  logic [1:0]  w_grant;
  logic        w_cyc;
  logic [3:0]  w_resp;
  logic [31:0] w_addr, w_mdat;

  always_comb begin
    if (sel) begin
      w_grant = r_grant;
      w_cyc   = r_s_cyc;
      w_resp  = {r_m1_err, r_m1_ack, r_m0_err, r_m0_ack};
      w_addr  = r_s_addr;
      w_mdat  = r_m_dat;
    end else begin
      w_grant = f_grant;
      w_cyc   = f_s_cyc;
      w_resp  = {f_m1_err, f_m1_ack, f_m0_err, f_m0_ack};
      w_addr  = f_s_addr;
      w_mdat  = f_m_dat;
    end
  end

  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      n_cmp++;
      if (w_grant !== e.grant || w_cyc !== e.cyc
          || w_resp !== e.resp
          || (e.chk && (w_addr !== e.addr || w_mdat !== DR))) begin
        n_bad++;
        $display("FAIL %s: got g=%b cyc=%b resp=%b addr=%h dat=%h want g=%b cyc=%b resp=%b addr=%h dat=%h",
          e.tag, w_grant, w_cyc, w_resp, w_addr, w_mdat,
          e.grant, e.cyc, e.resp, e.addr, DR);
      end
    end else if (w_resp != 4'b0000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_resp: got %b want 0000", w_resp);
    end
  end

  // resp is {m1_err, m1_ack, m0_err, m0_ack}
  task automatic ex(input string t, input logic [1:0] g,
                    input logic c, input logic [3:0] r,
                    input logic k = 1'b0,
                    input logic [31:0] a = '0);
    exp_t x;
    x.tag = t; x.grant = g; x.cyc = c;
    x.resp = r; x.chk = k; x.addr = a;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_req(input logic v);
    m0_cyc = v;
    m0_stb = v;
  endtask

  task automatic m1_req(input logic v);
    m1_cyc = v;
    m1_stb = v;
  endtask

  initial begin
    rst_i = 1'b0;
    m0_we = 1'b0; m1_we = 1'b1;
    m0_sel = 4'hF; m1_sel = 4'h3;
    m0_addr = A0; m1_addr = A1;
    m0_dat = 32'h1111_0000; m1_dat = 32'h2222_0000;
    s_dat_i = DR;
    m0_req(1'b1); m1_req(1'b1);
    s_ack = 1'b1; s_err = 1'b1;

    tick();
    ex("rst_hold", 2'b00, 1'b0, 4'b0000); tick();
    s_ack = 1'b0; s_err = 1'b0; rst_i = 1'b1;
    ex("rst_rel", 2'b00, 1'b0, 4'b0000); tick();
    ex("fp_grant", 2'b10, 1'b1, 4'b0000, 1'b1, A1); tick();
    s_ack = 1'b1;
    ex("fp_ack", 2'b10, 1'b1, 4'b0100, 1'b1, A1); tick();
    s_err = 1'b1;
    ex("fp_ack_err", 2'b10, 1'b1, 4'b1100); tick();
    s_ack = 1'b0; s_err = 1'b0;
    m0_req(1'b0); m1_req(1'b0);
    ex("fp_rel", 2'b10, 1'b0, 4'b0000); tick();

    m0_req(1'b1);
    ex("b_idle", 2'b00, 1'b0, 4'b0000); tick();
    m1_req(1'b1); s_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ex("b_beat", 2'b01, 1'b1, 4'b0001, 1'b1, A0);
      tick();
    end
    m0_req(1'b0); s_ack = 1'b0;
    ex("b_drop", 2'b01, 1'b0, 4'b0000); tick();
    ex("b_gap", 2'b00, 1'b0, 4'b0000); tick();
    ex("b_m1", 2'b10, 1'b1, 4'b0000, 1'b1, A1); tick();

    ex("to_stb2", 2'b10, 1'b1, 4'b0000); tick();
    ex("to_stb3", 2'b10, 1'b1, 4'b0000); tick();
    ex("to_stb4_err", 2'b10, 1'b1, 4'b1000); tick();
    ex("to_clear", 2'b10, 1'b1, 4'b0000); tick();
    ex("to_stb2b", 2'b10, 1'b1, 4'b0000); tick();
    ex("to_stb3b", 2'b10, 1'b1, 4'b0000); tick();
    s_ack = 1'b1;
    ex("to_ack_wins", 2'b10, 1'b1, 4'b0100); tick();
    s_ack = 1'b0;
    ex("to_after_ack", 2'b10, 1'b1, 4'b0000); tick();
    m1_req(1'b0);
    ex("to_rel", 2'b10, 1'b0, 4'b0000); tick();

    m0_req(1'b1);
    ex("ar_idle", 2'b00, 1'b0, 4'b0000); tick();
    ex("ar_gnt", 2'b01, 1'b1, 4'b0000, 1'b1, A0); tick();
    rst_i = 1'b0;
    ex("ar_async", 2'b00, 1'b0, 4'b0000); tick();
    rst_i = 1'b1;
    ex("ar_rel", 2'b00, 1'b0, 4'b0000); tick();
    ex("ar_regnt", 2'b01, 1'b1, 4'b0000); tick();
    m0_req(1'b0);
    ex("ar_drop", 2'b01, 1'b0, 4'b0000); tick();
    ex("ar_idle2", 2'b00, 1'b0, 4'b0000); tick();

    rst_i = 1'b0;
    ex("rr_rst", 2'b00, 1'b0, 4'b0000); tick();
    rst_i = 1'b1; sel = 1'b1;
    m0_req(1'b1); m1_req(1'b1);
    ex("rr_idle0", 2'b00, 1'b0, 4'b0000); tick();
    for (int i = 0; i < 4; i++) begin
      s_ack = 1'b1;
      if (i % 2 == 1)
        ex("rr_gnt1", 2'b10, 1'b1, 4'b0100);
      else
        ex("rr_gnt0", 2'b01, 1'b1, 4'b0001);
      @(negedge clk);
      #1;
      if (i % 2 == 1) m1_req(1'b0);
      else m0_req(1'b0);
      s_ack = 1'b0;
      tick();
      m0_req(1'b1); m1_req(1'b1);
      ex("rr_idle", 2'b00, 1'b0, 4'b0000);
      tick();
    end

    m0_req(1'b0); m1_req(1'b0);
    repeat (4) tick();
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
